// File: rtl/vcobuf_mph.sv
// Multi-phase VCO output buffer: divides clk by a run-time ratio and emits
// N_PH true/complement clock pairs, each tap one clk cycle behind the previous.
module vcobuf_mph #(
    parameter int W       = 4,
    parameter int N_PH    = 4,
    parameter int DIV_RST = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  real             avdd,
    input  logic            en,
    input  logic [W-1:0]    div,
    input  logic            div_ld,
    output logic [N_PH-1:0] hck,
    output logic [N_PH-1:0] hckb,
    output logic            pend,
    output logic            active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [W-1:0] RATIO_RST = W'(DIV_RST);
    localparam logic [W-1:0] RATIO_MIN = W'(2);
    localparam logic [W-1:0] ONE_W     = W'(1);
    localparam logic [W:0]   ONE_W1    = (W+1)'(1);

    state_t          state_reg, state_next;
    logic [W-1:0]    cnt_reg, cnt_next;
    logic [W-1:0]    r_reg, r_next;
    logic [W-1:0]    p_reg, p_next;
    logic            pend_reg, pend_next;
    logic [N_PH-1:0] hck_reg, hck_next;

    logic            run_any;
    logic            last;
    logic            wrap;
    logic            base;
    logic [W-1:0]    div_clamped;
    logic [W:0]      half;
    logic            unused_avdd;

    // Supply pin is modelled only so the netlist matches the analog macro.
    assign unused_avdd = (avdd > 0.0);

    assign run_any     = (state_reg != IDLE);
    assign last        = (cnt_reg == (r_reg - ONE_W));
    assign wrap        = run_any && last;
    assign div_clamped = (div < RATIO_MIN) ? RATIO_MIN : div;
    assign half        = ({1'b0, r_reg} + ONE_W1) >> 1;
    assign base        = run_any && ({1'b0, cnt_reg} < half);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = last ? IDLE : STOP;
            STOP: begin
                if (en)        state_next = RUN;
                else if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A load on the wrap edge must not be applied there, so the apply uses
    // the old pending value and the new load then re-arms pend.
    always_comb begin
        cnt_next  = (run_any && !last) ? (cnt_reg + ONE_W) : '0;
        r_next    = r_reg;
        p_next    = p_reg;
        pend_next = pend_reg;
        if (wrap && pend_reg) begin
            r_next    = p_reg;
            pend_next = 1'b0;
        end
        if (div_ld) begin
            if (run_any) begin
                p_next    = div_clamped;
                pend_next = 1'b1;
            end else begin
                r_next = div_clamped;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_PH; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign hck_next[gi] = base;
            end else begin : g_body
                assign hck_next[gi] = hck_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            r_reg     <= RATIO_RST;
            p_reg     <= RATIO_RST;
            pend_reg  <= 1'b0;
            hck_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            r_reg     <= r_next;
            p_reg     <= p_next;
            pend_reg  <= pend_next;
            hck_reg   <= hck_next;
        end
    end

    assign hck    = hck_reg;
    assign hckb   = ~hck_reg;
    assign pend   = pend_reg;
    assign active = run_any;

endmodule
